// File: rtl/board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : board_renderer
// Purpose  : Scans the board RAM row-major and paints each cell as a square
//            of pixels through the VGA write port.
// Revision : 1.0 - initial release
// ============================================================================
module board_renderer #(
    parameter int         BOARD_W   = 10,
    parameter int         BOARD_H   = 20,
    parameter int         BLOCK_PX  = 4,
    parameter int         X_ORIGIN  = 60,
    parameter int         Y_ORIGIN  = 20,
    parameter logic [5:0] BG_COLOUR = 6'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic [7:0] ram_addr,
    input  logic [5:0] ram_Q,
    output logic [7:0] X_vga,
    output logic [6:0] Y_vga,
    output logic [5:0] colour_out,
    output logic       writeEn,
    output logic       complete
);

    localparam int XW = (BOARD_W  > 1) ? $clog2(BOARD_W)  : 1;
    localparam int YW = (BOARD_H  > 1) ? $clog2(BOARD_H)  : 1;
    localparam int PW = (BLOCK_PX > 1) ? $clog2(BLOCK_PX) : 1;

    localparam logic [XW-1:0] C_X_LAST  = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] C_Y_LAST  = YW'(BOARD_H - 1);
    localparam logic [PW-1:0] C_PX_LAST = PW'(BLOCK_PX - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] DRAW  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    r_state;
    logic          r_armed;
    logic [XW-1:0] r_cell_x;
    logic [YW-1:0] r_cell_y;
    logic [PW-1:0] r_px;
    logic [PW-1:0] r_py;
    logic [5:0]    r_cell_colour;

    logic [7:0]    w_cell_addr;
    logic [7:0]    w_pix_x;
    logic [6:0]    w_pix_y;
    logic          w_last_cell;
    logic          w_last_pixel;

    assign w_cell_addr  = 8'(r_cell_y) * 8'(BOARD_W) + 8'(r_cell_x);
    assign w_pix_x      = 8'(X_ORIGIN) + 8'(r_cell_x) * 8'(BLOCK_PX) + 8'(r_px);
    assign w_pix_y      = 7'(Y_ORIGIN) + 7'(r_cell_y) * 7'(BLOCK_PX) + 7'(r_py);
    assign w_last_cell  = (r_cell_x == C_X_LAST) && (r_cell_y == C_Y_LAST);
    assign w_last_pixel = (r_px == C_PX_LAST) && (r_py == C_PX_LAST);

    // Outputs decode directly from state so the address meets the RAM in FETCH
    // and its data is ready one cycle later in LATCH.
    assign ram_addr   = (r_state == FETCH) ? w_cell_addr : 8'd0;
    assign writeEn    = (r_state == DRAW);
    assign X_vga      = (r_state == DRAW) ? w_pix_x : 8'd0;
    assign Y_vga      = (r_state == DRAW) ? w_pix_y : 7'd0;
    assign colour_out = (r_state == DRAW) ? r_cell_colour : 6'd0;
    assign complete   = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_armed       <= 1'b1;
            r_cell_x      <= '0;
            r_cell_y      <= '0;
            r_px          <= '0;
            r_py          <= '0;
            r_cell_colour <= 6'd0;
        end else if (r_state == IDLE) begin
            if (!enable) begin
                r_armed <= 1'b1;
            end else if (r_armed) begin
                r_armed  <= 1'b0;
                r_cell_x <= '0;
                r_cell_y <= '0;
                r_px     <= '0;
                r_py     <= '0;
                r_state  <= FETCH;
            end
        end else if (!enable) begin
            // Abort: the controller deselected us mid-operation.
            r_state  <= IDLE;
            r_armed  <= 1'b1;
            r_cell_x <= '0;
            r_cell_y <= '0;
            r_px     <= '0;
            r_py     <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    r_state <= LATCH;
                end
                LATCH: begin
                    r_cell_colour <= (ram_Q == 6'd0) ? BG_COLOUR : ram_Q;
                    r_px          <= '0;
                    r_py          <= '0;
                    r_state       <= DRAW;
                end
                DRAW: begin
                    if (r_px == C_PX_LAST) begin
                        r_px <= '0;
                        r_py <= r_py + PW'(1);
                    end else begin
                        r_px <= r_px + PW'(1);
                    end
                    if (w_last_pixel) begin
                        r_py <= '0;
                        if (w_last_cell) begin
                            r_state <= DONE;
                        end else begin
                            if (r_cell_x == C_X_LAST) begin
                                r_cell_x <= '0;
                                r_cell_y <= r_cell_y + YW'(1);
                            end else begin
                                r_cell_x <= r_cell_x + XW'(1);
                            end
                            r_state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_renderer.sv
`default_nettype none
// Testbench for board_renderer: RAM model with 1-cycle read latency, pixel
// capture into a framebuffer, and directed scan/abort/reset sequences.
module tb_board_renderer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] ram_addr;
    logic [5:0] ram_Q;
    logic [7:0] X_vga;
    logic [6:0] Y_vga;
    logic [5:0] colour_out;
    logic       writeEn;
    logic       complete;

    always #5 clk = ~clk;

    board_renderer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .ram_addr   (ram_addr),
        .ram_Q      (ram_Q),
        .X_vga      (X_vga),
        .Y_vga      (Y_vga),
        .colour_out (colour_out),
        .writeEn    (writeEn),
        .complete   (complete)
    );

    logic [5:0] mem [0:199];
    always @(posedge clk) ram_Q <= (ram_addr < 8'd200) ? mem[ram_addr] : 6'h3F;

    typedef struct {
        int         x;
        int         y;
        logic [5:0] exp;
    } vec_t;

    vec_t vt [13];

    int checks = 0;
    int errors = 0;

    // rel counts sampled cycles; rel 0 is the first FETCH cycle of a scan
    int         rel;
    bit         logging;
    int         wr_cnt, oob, comp_cnt, comp_rel, bad_addr;
    int         hits [0:39][0:79];
    logic [5:0] fb   [0:39][0:79];
    logic [7:0] addr_log [0:3999];
    logic       we_log   [0:3999];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        int xi, yi;
        @(negedge clk);
        if (logging) begin
            if (writeEn) begin
                wr_cnt++;
                xi = int'(X_vga) - 60;
                yi = int'(Y_vga) - 20;
                if (xi >= 0 && xi < 40 && yi >= 0 && yi < 80) begin
                    hits[xi][yi]++;
                    fb[xi][yi] = colour_out;
                end else begin
                    oob++;
                end
            end
            if (complete) begin
                comp_cnt++;
                comp_rel = rel;
            end
            if (ram_addr >= 8'd200) bad_addr++;
            if (rel < 4000) begin
                addr_log[rel] = ram_addr;
                we_log[rel]   = writeEn;
            end
            rel++;
        end
    endtask

    task automatic start_log();
        wr_cnt = 0; oob = 0; comp_cnt = 0; comp_rel = -1; bad_addr = 0;
        for (int i = 0; i < 40; i++)
            for (int j = 0; j < 80; j++) begin
                hits[i][j] = 0;
                fb[i][j]   = 6'h3F;
            end
        rel     = 0;
        logging = 1'b1;
    endtask

    // Bounded wait for complete, then linger to confirm no rescan starts.
    task automatic run_to_complete();
        while (comp_cnt == 0 && rel < 3700) step();
        repeat (100) step();
    endtask

    task automatic check_scan(input string tag, input bit bg_only);
        int badhit, badcol, badseq;
        badhit = 0; badcol = 0; badseq = 0;
        for (int i = 0; i < 40; i++)
            for (int j = 0; j < 80; j++) begin
                if (hits[i][j] != 1) badhit++;
                if (bg_only && fb[i][j] !== 6'd0) badcol++;
            end
        for (int k = 0; k < 200; k++) begin
            logic [7:0] kk;
            kk = 8'(k);
            if (addr_log[k*18] !== kk) badseq++;
            for (int c = 0; c < 18; c++)
                if (we_log[k*18 + c] !== (c >= 2)) badseq++;
        end
        check({tag, "_wr_count"}, wr_cnt, 3200);
        check({tag, "_out_of_area"}, oob, 0);
        check({tag, "_pixel_hits"}, badhit, 0);
        check({tag, "_addr_we_seq"}, badseq, 0);
        check({tag, "_bad_addr"}, bad_addr, 0);
        check({tag, "_complete_cnt"}, comp_cnt, 1);
        // 3600 cycles after rel 0, i.e. the 3601st cycle counting FETCH as 1
        check({tag, "_complete_at"}, comp_rel, 3600);
        if (bg_only) check({tag, "_bg_colour"}, badcol, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{60, 20, 6'h30};
        vt[1]  = '{63, 23, 6'h30};
        vt[2]  = '{64, 20, 6'h00};
        vt[3]  = '{96, 20, 6'h15};
        vt[4]  = '{99, 23, 6'h15};
        vt[5]  = '{60, 24, 6'h03};
        vt[6]  = '{63, 27, 6'h03};
        vt[7]  = '{62, 25, 6'h03};
        vt[8]  = '{64, 24, 6'h00};
        vt[9]  = '{96, 96, 6'h0C};
        vt[10] = '{99, 99, 6'h0C};
        vt[11] = '{95, 99, 6'h00};
        vt[12] = '{80, 60, 6'h00};

        logging = 1'b0;
        reset_n = 1'b0;
        enable  = 1'b1;
        for (int i = 0; i < 200; i++) mem[i] = 6'd0;

        // Reset held with enable high: everything quiet.
        repeat (3) begin
            step();
            check("reset_we", writeEn, 0);
            check("reset_complete", complete, 0);
            check("reset_addr", ram_addr, 0);
            check("reset_pixel", {X_vga, Y_vga, colour_out}, 0);
        end

        // Release reset with enable high: scan of an empty board.
        reset_n = 1'b1;
        start_log();
        run_to_complete();
        check_scan("zero", 1'b1);

        // Patterned board, rearmed by one low cycle of enable.
        mem[0] = 6'h30; mem[9] = 6'h15; mem[10] = 6'h03; mem[199] = 6'h0C;
        enable = 1'b0;
        step();
        enable = 1'b1;
        start_log();
        run_to_complete();
        check_scan("pat", 1'b0);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("pix_%0d_%0d", vt[i].x, vt[i].y),
                  fb[vt[i].x - 60][vt[i].y - 20], vt[i].exp);
        end

        // Abort mid-DRAW at rel 500 (cell 27, 12 pixels drawn).
        enable = 1'b0;
        step();
        enable = 1'b1;
        start_log();
        repeat (500) step();
        check("abort_pre_we", we_log[499], 1);
        enable = 1'b0;
        step();
        check("abort_we", writeEn, 0);
        check("abort_complete", complete, 0);
        check("abort_addr", ram_addr, 0);
        repeat (20) step();
        check("abort_no_complete", comp_cnt, 0);
        check("abort_pixels_kept", wr_cnt, 444);
        enable = 1'b1;
        start_log();
        run_to_complete();
        check_scan("restart", 1'b0);

        // Reset in the middle of DRAW.
        enable = 1'b0;
        step();
        enable = 1'b1;
        start_log();
        repeat (100) step();
        check("rst_pre_we", we_log[99], 1);
        reset_n = 1'b0;
        step();
        check("rst_we", writeEn, 0);
        check("rst_complete", complete, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_pixel", {X_vga, Y_vga, colour_out}, 0);
        step();
        reset_n = 1'b1;
        start_log();
        run_to_complete();
        check_scan("after_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
